aes_stream_top: RTL

AES_STREAM_TOP -- requirements
Module: aes_stream_top

---
 rtl/aes_stream_pkg.sv | 25 ++
 rtl/aes_128.sv | 99 +++++++++
 rtl/aes_stream_fifo.sv | 67 ++++++
 rtl/aes_stream_top.sv | 121 ++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg
// Shared constants and helpers for the AES streaming wrapper.
//   AES_BLK_W : cipher block width in bits
//   KEY_W     : cipher key width in bits
//   cnt_w()   : bits needed to hold a counter ranging 0..max_val
package aes_stream_pkg;

  localparam int AES_BLK_W = 128;
  localparam int KEY_W     = 128;

  // Smallest width w with 2**w > max_val, so the value max_val itself fits.
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= max_val) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_128.sv
// aes_128
// Free-running, fully pipelined AES-128 encryption core. No reset, no
// handshake: whatever is on state/key is encrypted and appears on out exactly
// 21 cycles later (one input stage plus two stages per round).
// Ports:
//   clk   in   rising-edge clock
//   state in   128-bit plaintext (byte 0 in bits [127:120])
//   key   in   128-bit cipher key
//   out   out  128-bit ciphertext
module aes_128 (
  input  logic         clk,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (y[0] ? x : 8'h00);
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r, y;
    y = gm(b, b);
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      r = gm(r, y);
      y = gm(y, y);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  function automatic logic [127:0] key_f(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp;
    {w0, w1, w2, w3} = k;
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
  function automatic logic [127:0] round_f(input logic [127:0] s, input logic [127:0] k,
                                           input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      o[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
        {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  logic [127:0] st_q [21];
  logic [127:0] ky_q [20];

  // Odd stages expand the round key, even stages apply the round with it.
  always_ff @(posedge clk) begin
    st_q[0] <= state ^ key;
    ky_q[0] <= key;
    for (int r = 1; r <= 10; r++) begin
      st_q[2*r-1] <= st_q[2*r-2];
      ky_q[2*r-1] <= key_f(ky_q[2*r-2], rcon(r));
      st_q[2*r]   <= round_f(st_q[2*r-1], ky_q[2*r-1], (r == 10));
    end
    for (int r = 1; r < 10; r++) begin
      ky_q[2*r] <= ky_q[2*r-1];
    end
  end

  assign out = st_q[20];

endmodule

// File: rtl/aes_stream_fifo.sv
// stream_fifo
// First-word-fall-through FIFO. The head entry is presented combinationally
// and reads as zero while empty. A write on a full FIFO is accepted only when
// a read happens in the same cycle.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   wr_en_i/wr_data_i  push
//   rd_en_i            pop head (ignored while empty)
//   rd_data_o          head entry
//   empty_o, count_o   occupancy
module stream_fifo import aes_stream_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      rd_en_i,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr_s, do_rd_s;

  assign do_rd_s   = rd_en_i && (cnt_q != CNT_W'(0));
  assign do_wr_s   = wr_en_i && ((cnt_q != CNT_W'(DEPTH)) || do_rd_s);
  assign empty_o   = (cnt_q == CNT_W'(0));
  assign count_o   = cnt_q;
  assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Occupancy next state; write plus read leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents are qualified by the count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_stream_top.sv
// aes_stream_top
// Valid/ready streaming wrapper around the free-running aes_128 core. Blocks
// are admitted only when a FIFO slot is guaranteed for them (credits), tracked
// through a valid/tag shift register matching the core latency, and buffered
// in an output FIFO. The key may only change while the pipe is empty.
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready/in_state/in_tag   input block stream
//   key_load/key_in/key_err             key update, rejection pulse
//   out_valid/out_ready/out_data/out_tag ciphertext stream (FIFO head)
//   busy                                 blocks in flight or buffered
//   blk_count                            output handshakes, wrapping
module aes_stream_top import aes_stream_pkg::*; #(
  parameter int AES_LAT = 21,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_state,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 key_load,
  input  logic [KEY_W-1:0]     key_in,
  output logic                 key_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy,
  output logic [31:0]          blk_count
);

  localparam int FCNT_W = cnt_w(DEPTH);
  localparam int ICNT_W = cnt_w(AES_LAT);
  localparam int CR_W   = cnt_w(DEPTH + AES_LAT);

  logic                       rdy_en_q;
  logic [KEY_W-1:0]           key_q;
  logic                       key_err_q;
  logic [AES_LAT-1:0]         vld_q;
  logic [TAG_W-1:0]           tag_q [AES_LAT];
  logic [ICNT_W-1:0]          infl_q, infl_d;
  logic [31:0]                blk_cnt_q;
  logic [FCNT_W-1:0]          fifo_cnt_s;
  logic                       fifo_empty_s;
  logic [TAG_W+AES_BLK_W-1:0] head_s;
  logic [AES_BLK_W-1:0]       aes_out_s;
  logic [CR_W-1:0]            credit_s;
  logic                       accept_s, retire_s, hs_s;

  // Credits count free FIFO slots not already promised to a block in flight,
  // so the retire-side FIFO write can never hit a full FIFO without a pop.
  assign credit_s  = CR_W'(DEPTH) - CR_W'(fifo_cnt_s) - CR_W'(infl_q);
  assign in_ready  = rdy_en_q && (credit_s != CR_W'(0)) && !key_load;
  assign accept_s  = in_valid && in_ready;
  assign retire_s  = vld_q[AES_LAT-1];
  assign out_valid = !fifo_empty_s;
  assign hs_s      = out_valid && out_ready;
  assign out_data  = head_s[AES_BLK_W-1:0];
  assign out_tag   = head_s[AES_BLK_W +: TAG_W];
  assign busy      = (infl_q != ICNT_W'(0)) || (fifo_cnt_s != FCNT_W'(0));
  assign key_err   = key_err_q;
  assign blk_count = blk_cnt_q;

  aes_128 u_aes (
    .clk   (clk),
    .state (in_state),
    .key   (key_q),
    .out   (aes_out_s)
  );

  stream_fifo #(
    .WIDTH (TAG_W + AES_BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (retire_s),
    .wr_data_i ({tag_q[AES_LAT-1], aes_out_s}),
    .rd_en_i   (hs_s),
    .rd_data_o (head_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_cnt_s)
  );

  // In-flight count; accept and retire in the same cycle cancel out.
  always_comb begin
    infl_d = infl_q;
    case ({accept_s, retire_s})
      2'b10:   infl_d = infl_q + ICNT_W'(1);
      2'b01:   infl_d = infl_q - ICNT_W'(1);
      default: infl_d = infl_q;
    endcase
  end

  // Valid/tag pipeline alongside the core, key register, counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q  <= 1'b0;
      key_q     <= '0;
      key_err_q <= 1'b0;
      vld_q     <= '0;
      infl_q    <= '0;
      blk_cnt_q <= 32'd0;
      for (int i = 0; i < AES_LAT; i++) tag_q[i] <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      vld_q    <= {vld_q[AES_LAT-2:0], accept_s};
      tag_q[0] <= in_tag;
      for (int i = 1; i < AES_LAT; i++) tag_q[i] <= tag_q[i-1];
      infl_q   <= infl_d;
      if (hs_s) blk_cnt_q <= blk_cnt_q + 32'd1;
      // Changing the key under a block in flight would corrupt it.
      if (key_load && !busy && !accept_s) key_q <= key_in;
      key_err_q <= key_load && (busy || accept_s);
    end
  end

endmodule
